mesm6_membus_arbiter: RTL and testbench



---
 rtl/mesm6_pkg.sv | 10 +
 rtl/mesm6_bus_timeout.sv | 32 +++
 rtl/mesm6_membus_arbiter.sv | 107 ++++++++++
 tb/tb_mesm6_membus_arbiter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/mesm6_pkg.sv
// mesm6_pkg: shared types and widths for the MESM-6 memory bus arbiter.
package mesm6_pkg;

    localparam int MESM6_ADDR_W = 15;
    localparam int MESM6_DATA_W = 48;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} arb_state_t;
    typedef enum logic {GNT_I, GNT_D} arb_grant_t;

endpackage

// File: rtl/mesm6_bus_timeout.sv
// mesm6_bus_timeout: access watchdog; load starts the count at 1 so expired
// marks the TIMEOUT-th cycle the memory has been waited on.
module mesm6_bus_timeout #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (load)
            cnt <= CW'(1);
        else if (en)
            cnt <= cnt + CW'(1);
    end

    assign expired = cnt == LIMIT;

endmodule

// File: rtl/mesm6_membus_arbiter.sv
// mesm6_membus_arbiter: shares one memory port between the MESM-6 ibus and dbus.
// Define MESM6_ARB_RR_EN for round-robin arbitration instead of fixed dbus priority.
module mesm6_membus_arbiter
    import mesm6_pkg::*;
#(
    parameter int ADDR_W  = MESM6_ADDR_W,
    parameter int DATA_W  = MESM6_DATA_W,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ibus_fetch,
    input  logic [ADDR_W-1:0] ibus_addr,
    output logic [DATA_W-1:0] ibus_input,
    output logic              ibus_done,
    input  logic              dbus_read,
    input  logic              dbus_write,
    input  logic [ADDR_W-1:0] dbus_addr,
    input  logic [DATA_W-1:0] dbus_output,
    output logic [DATA_W-1:0] dbus_input,
    output logic              dbus_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              bus_error
);

    arb_state_t state;
    arb_grant_t grant;
    logic       any_req, dbus_req, pick_d, expired;

    assign dbus_req = dbus_read | dbus_write;
    assign any_req  = ibus_fetch | dbus_req;

`ifdef MESM6_ARB_RR_EN
    arb_grant_t last_grant;
    assign pick_d = dbus_req & (!ibus_fetch | last_grant == GNT_I);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            last_grant <= GNT_I;
        else if (state == IDLE && any_req)
            last_grant <= pick_d ? GNT_D : GNT_I;
    end
`else
    assign pick_d = dbus_req;
`endif

    mesm6_bus_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (state == RESP),
        .load    (state == IDLE && any_req),
        .en      (state == ACCESS),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            grant      <= GNT_I;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            ibus_input <= '0;
            dbus_input <= '0;
            ibus_done  <= 1'b0;
            dbus_done  <= 1'b0;
            bus_error  <= 1'b0;
        end else begin
            ibus_done <= 1'b0;
            dbus_done <= 1'b0;
            bus_error <= 1'b0;
            case (state)
                IDLE: if (any_req) begin
                    state     <= ACCESS;
                    grant     <= pick_d ? GNT_D : GNT_I;
                    mem_req   <= 1'b1;
                    mem_we    <= pick_d & dbus_write;
                    mem_addr  <= pick_d ? dbus_addr : ibus_addr;
                    mem_wdata <= dbus_output;
                end
                // An ack on the final counted cycle still wins over the timeout.
                ACCESS: if (mem_ack || expired) begin
                    state     <= RESP;
                    mem_req   <= 1'b0;
                    bus_error <= !mem_ack;
                    ibus_done <= grant == GNT_I;
                    dbus_done <= grant == GNT_D;
                    if (!mem_we && grant == GNT_I)
                        ibus_input <= mem_ack ? mem_rdata : '1;
                    if (!mem_we && grant == GNT_D)
                        dbus_input <= mem_ack ? mem_rdata : '1;
                end
                RESP: begin
                    state  <= IDLE;
                    mem_we <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mesm6_membus_arbiter.sv
// tb_mesm6_membus_arbiter: table-driven single transactions plus directed
// contention, stray-ack and asynchronous-reset sequences (TIMEOUT = 4).
module tb_mesm6_membus_arbiter;

    localparam int TO = 4;
    localparam logic [47:0] ONES = 48'hFFFF_FFFF_FFFF;

    logic        clk = 1'b0, reset_n = 1'b0;
    logic        ibus_fetch = 0, dbus_read = 0, dbus_write = 0, mem_ack = 0;
    logic [14:0] ibus_addr = '0, dbus_addr = '0;
    logic [47:0] dbus_output = '0, mem_rdata = '0;
    logic [47:0] ibus_input, dbus_input, mem_wdata;
    logic [14:0] mem_addr;
    logic        ibus_done, dbus_done, mem_req, mem_we, bus_error;

    int passed = 0, total = 0;

    always #5 clk = ~clk;

    mesm6_membus_arbiter #(.ADDR_W(15), .DATA_W(48), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .ibus_fetch(ibus_fetch), .ibus_addr(ibus_addr), .ibus_input(ibus_input), .ibus_done(ibus_done),
        .dbus_read(dbus_read), .dbus_write(dbus_write), .dbus_addr(dbus_addr),
        .dbus_output(dbus_output), .dbus_input(dbus_input), .dbus_done(dbus_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_error(bus_error)
    );

    typedef struct {
        logic        f, r, w;
        logic [14:0] ia, da;
        logic [47:0] wd, rd;
        int          waits;
        logic [14:0] ea;
        logic        ewe, ei, ed, eerr;
        logic [47:0] eii, edi;
    } vec_t;

    vec_t vt[7];

    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else passed++;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " mem_req"}, 48'(mem_req), 48'd0);
        chk({tag, " mem_we"}, 48'(mem_we), 48'd0);
        chk({tag, " mem_addr"}, 48'(mem_addr), 48'd0);
        chk({tag, " mem_wdata"}, mem_wdata, 48'd0);
        chk({tag, " ibus_input"}, ibus_input, 48'd0);
        chk({tag, " dbus_input"}, dbus_input, 48'd0);
        chk({tag, " dones"}, 48'({ibus_done, dbus_done}), 48'd0);
        chk({tag, " bus_error"}, 48'(bus_error), 48'd0);
    endtask

    // Ack in the current ACCESS cycle; returns at the RESP negedge.
    task automatic ack_now(input logic [47:0] rd);
        mem_ack = 1'b1;
        mem_rdata = rd;
        @(negedge clk);
        mem_ack = 1'b0;
    endtask

    task automatic run(input int idx, input vec_t v);
        int n;
        string t;
        t = $sformatf("v%0d", idx);
        ibus_fetch = v.f; dbus_read = v.r; dbus_write = v.w;
        ibus_addr = v.ia; dbus_addr = v.da; dbus_output = v.wd;
        @(negedge clk);
        chk({t, " mem_addr"}, 48'(mem_addr), 48'(v.ea));
        chk({t, " mem_we"}, 48'(mem_we), 48'(v.ewe));
        if (v.ewe) chk({t, " mem_wdata"}, mem_wdata, v.wd);
        n = (v.waits >= TO) ? TO : v.waits + 1;
        for (int c = 0; c < n; c++) begin
            chk({t, " mem_req held"}, 48'(mem_req), 48'd1);
            if (c == v.waits) begin
                mem_ack = 1'b1;
                mem_rdata = v.rd;
            end
            @(negedge clk);
            mem_ack = 1'b0;
        end
        chk({t, " resp mem_req"}, 48'(mem_req), 48'd0);
        chk({t, " ibus_done"}, 48'(ibus_done), 48'(v.ei));
        chk({t, " dbus_done"}, 48'(dbus_done), 48'(v.ed));
        chk({t, " bus_error"}, 48'(bus_error), 48'(v.eerr));
        ibus_fetch = 0; dbus_read = 0; dbus_write = 0;
        @(negedge clk);
        chk({t, " idle dones"}, 48'({ibus_done, dbus_done, bus_error}), 48'd0);
        chk({t, " ibus_input"}, ibus_input, v.eii);
        chk({t, " dbus_input"}, dbus_input, v.edi);
    endtask

    initial begin
        vt[0] = '{1'b1, 1'b0, 1'b0, 15'o100, 15'd0, 48'h0, 48'h1234_5678_9ABC, 0,
                  15'o100, 1'b0, 1'b1, 1'b0, 1'b0, 48'h1234_5678_9ABC, 48'h0};
        vt[1] = '{1'b0, 1'b1, 1'b0, 15'd0, 15'd5, 48'h0, 48'hA5A5_5A5A_0F0F, 2,
                  15'd5, 1'b0, 1'b0, 1'b1, 1'b0, 48'h1234_5678_9ABC, 48'hA5A5_5A5A_0F0F};
        vt[2] = '{1'b0, 1'b0, 1'b1, 15'd0, 15'o77777, 48'hFFFF_0000_0001, 48'hDEAD, 1,
                  15'o77777, 1'b1, 1'b0, 1'b1, 1'b0, 48'h1234_5678_9ABC, 48'hA5A5_5A5A_0F0F};
        vt[3] = '{1'b0, 1'b1, 1'b1, 15'd0, 15'd7, 48'h111, 48'hBEEF, 0,
                  15'd7, 1'b1, 1'b0, 1'b1, 1'b0, 48'h1234_5678_9ABC, 48'hA5A5_5A5A_0F0F};
        vt[4] = '{1'b0, 1'b1, 1'b0, 15'd0, 15'd9, 48'h0, 48'h5555, 4,
                  15'd9, 1'b0, 1'b0, 1'b1, 1'b1, 48'h1234_5678_9ABC, ONES};
        vt[5] = '{1'b1, 1'b0, 1'b0, 15'd3, 15'd0, 48'h0, 48'h6666, 10,
                  15'd3, 1'b0, 1'b1, 1'b0, 1'b1, ONES, ONES};
        vt[6] = '{1'b1, 1'b0, 1'b0, 15'o200, 15'd0, 48'h0, 48'h0ABC, 3,
                  15'o200, 1'b0, 1'b1, 1'b0, 1'b0, 48'h0ABC, ONES};

        repeat (2) @(negedge clk);
        chk_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run(i, vt[i]);

        // Stray ack while idle must not complete anything or touch holding registers.
        mem_ack = 1'b1; mem_rdata = 48'h999;
        @(negedge clk);
        mem_ack = 1'b0;
        @(negedge clk);
        chk("stray dones", 48'({ibus_done, dbus_done, mem_req}), 48'd0);
        chk("stray ibus_input", ibus_input, 48'h0ABC);
        chk("stray dbus_input", dbus_input, ONES);

        // Contention: dbus first, fetch served 3 cycles after dbus_done.
        ibus_fetch = 1; ibus_addr = 15'o10; dbus_read = 1; dbus_addr = 15'd5;
        @(negedge clk);
        chk("cont1 grant", 48'(mem_addr), 48'd5);
        ack_now(48'h1111);
        chk("cont1 dbus_done", 48'({ibus_done, dbus_done}), 48'b01);
        dbus_read = 0;
        repeat (2) @(negedge clk);
        chk("cont1 fetch addr", 48'(mem_addr), 48'o10);
        ack_now(48'h2222);
        chk("cont1 ibus_done", 48'({ibus_done, dbus_done}), 48'b10);
        chk("cont1 dbus_input", dbus_input, 48'h1111);
        ibus_fetch = 0;
        @(negedge clk);

        // Second contention right after a dbus grant: round-robin favours the ibus.
        dbus_read = 1; dbus_addr = 15'd6;
        @(negedge clk);
        ack_now(48'h3333);
        ibus_fetch = 1;
        repeat (2) @(negedge clk);
`ifdef MESM6_ARB_RR_EN
        chk("cont2 grant", 48'(mem_addr), 48'o10);
`else
        chk("cont2 grant", 48'(mem_addr), 48'd6);
`endif
        ack_now(48'h4444);
        ibus_fetch = 0; dbus_read = 0;
        @(negedge clk);

        // Asynchronous reset in the middle of a waited access.
        dbus_read = 1; dbus_addr = 15'h1F;
        @(negedge clk);
        chk("rst pre mem_req", 48'(mem_req), 48'd1);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 chk_zero("async rst");
        dbus_read = 0;
        @(negedge clk);
        @(negedge clk);
        chk("rst no done", 48'({ibus_done, dbus_done}), 48'd0);
        reset_n = 1'b1;
        @(negedge clk);
        ibus_fetch = 1; ibus_addr = 15'o55;
        @(negedge clk);
        chk("post rst addr", 48'(mem_addr), 48'o55);
        ack_now(48'h77);
        chk("post rst done", 48'({ibus_done, dbus_done}), 48'b10);
        ibus_fetch = 0;
        @(negedge clk);
        chk("post rst ibus_input", ibus_input, 48'h77);
        chk("post rst dbus_input", dbus_input, 48'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
